// File: rtl/fifo_pkg.sv
// fifo_pkg: shared default sizing for the DPRAM FIFO controller
package fifo_pkg;
   localparam int DEF_WIDTH = 4;
   localparam int DEF_AW    = 5;
   localparam int DEF_DEPTH = 2 ** DEF_AW;
endpackage

// File: rtl/fifo_ptr.sv
// fifo_ptr: modulo-DEPTH pointer with increment enable
module fifo_ptr
   import fifo_pkg::*;
#(
   parameter int AW    = DEF_AW,
   parameter int DEPTH = DEF_DEPTH
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          inc_i,
   output logic [AW-1:0] ptr_o
);
   logic [AW-1:0] ptr_q, ptr_d;
   // advance by one when enabled, wrapping from DEPTH-1 back to zero
   always_comb ptr_d = !inc_i ? ptr_q : (ptr_q == AW'(DEPTH - 1)) ? '0 : ptr_q + AW'(1);
   // pointer register, cleared asynchronously
   always_ff @(posedge clk or posedge rst)
      if (rst) ptr_q <= '0;
      else     ptr_q <= ptr_d;
   assign ptr_o = ptr_q;
endmodule

// File: rtl/dpram_fifo_ctrl.sv
// dpram_fifo_ctrl: runs an external sync-write/async-read dual-port RAM as a FIFO
module dpram_fifo_ctrl
   import fifo_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int AW    = DEF_AW,
   parameter int DEPTH = DEF_DEPTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             wr_en,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             rd_en,
   output logic [WIDTH-1:0] rd_data,
   output logic             rd_valid,
   output logic             full,
   output logic             empty,
   output logic [AW:0]      count,
   output logic             overflow,
   output logic             underflow,
   output logic [AW-1:0]    ram_a,
   output logic [WIDTH-1:0] ram_d,
   output logic             ram_we,
   output logic [AW-1:0]    ram_dpra,
   input  logic [WIDTH-1:0] ram_dpo
);
   logic [AW:0]      count_q, count_d;
   logic [WIDTH-1:0] rd_data_q, rd_data_d;
   logic             rd_valid_q, ovf_q, udf_q, ovf_d, udf_d;
   logic             rd_acc, wr_acc;

   assign full   = count_q == (AW+1)'(DEPTH);
   assign empty  = count_q == '0;
   assign rd_acc = rd_en && !empty && !rst;
   // a simultaneous read frees a slot, so a full FIFO still takes the write
   assign wr_acc = wr_en && (!full || rd_acc) && !rst;
   assign ram_we = wr_acc;
   assign ram_d  = wr_data;

   fifo_ptr #(.AW(AW), .DEPTH(DEPTH)) u_wr_ptr (.clk(clk), .rst(rst), .inc_i(wr_acc), .ptr_o(ram_a));
   fifo_ptr #(.AW(AW), .DEPTH(DEPTH)) u_rd_ptr (.clk(clk), .rst(rst), .inc_i(rd_acc), .ptr_o(ram_dpra));

   // next count, pop data and rejection pulses
   always_comb begin
      count_d   = count_q + (AW+1)'(wr_acc) - (AW+1)'(rd_acc);
      rd_data_d = rd_acc ? ram_dpo : rd_data_q;
      ovf_d     = wr_en && !wr_acc;
      udf_d     = rd_en && !rd_acc;
   end

   // state registers; reset discards stored words without touching the RAM
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         count_q    <= '0;
         rd_data_q  <= '0;
         rd_valid_q <= 1'b0;
         ovf_q      <= 1'b0;
         udf_q      <= 1'b0;
      end else begin
         count_q    <= count_d;
         rd_data_q  <= rd_data_d;
         rd_valid_q <= rd_acc;
         ovf_q      <= ovf_d;
         udf_q      <= udf_d;
      end

   assign count     = count_q;
   assign rd_data   = rd_data_q;
   assign rd_valid  = rd_valid_q;
   assign overflow  = ovf_q;
   assign underflow = udf_q;
endmodule

// File: tb/tb_dpram_fifo_ctrl.sv
// tb_dpram_fifo_ctrl: table, directed and random checks against a queue model
module tb_dpram_fifo_ctrl;
   logic       clk = 1'b0;
   logic       rst, wr_en, rd_en;
   logic [3:0] wr_data, rd_data, ram_d, ram_dpo;
   logic       rd_valid, full, empty, overflow, underflow, ram_we;
   logic [5:0] count;
   logic [4:0] ram_a, ram_dpra;
   logic [3:0] mem [32];

   int n_chk = 0, n_fail = 0;
   int q[$];
   int wp = 0, rp = 0, last = 0;

   typedef struct {
      logic       we;
      logic [3:0] wd;
      logic       re;
      int         cnt;
      logic       v;
      logic [3:0] d;
      logic       ovf;
      logic       udf;
   } vec_t;
   vec_t tbl [14];

   dpram_fifo_ctrl dut (
      .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
      .rd_data(rd_data), .rd_valid(rd_valid), .full(full), .empty(empty),
      .count(count), .overflow(overflow), .underflow(underflow),
      .ram_a(ram_a), .ram_d(ram_d), .ram_we(ram_we), .ram_dpra(ram_dpra), .ram_dpo(ram_dpo)
   );

   always #5 clk = ~clk;
   always_ff @(posedge clk) if (ram_we) mem[ram_a] <= ram_d;
   assign ram_dpo = mem[ram_dpra];

   task automatic chk(input string name, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic do_reset();
      rst = 1'b1; wr_en = 1'b1; rd_en = 1'b1; wr_data = 4'hF;
      #1;
      chk("rst_count", count, 0);
      chk("rst_empty", empty, 1);
      chk("rst_full", full, 0);
      chk("rst_ram_we", ram_we, 0);
      chk("rst_rd_valid", rd_valid, 0);
      chk("rst_rd_data", rd_data, 0);
      chk("rst_overflow", overflow, 0);
      chk("rst_underflow", underflow, 0);
      chk("rst_ram_a", ram_a, 0);
      chk("rst_ram_dpra", ram_dpra, 0);
      @(posedge clk); #1;
      wr_en = 1'b0; rd_en = 1'b0; rst = 1'b0;
      q.delete(); wp = 0; rp = 0; last = 0;
   endtask

   task automatic cycle(input logic we, input logic [3:0] wd, input logic re);
      int sz = q.size();
      bit rd_ok = re && sz > 0;
      bit wr_ok = we && (sz < 32 || rd_ok);
      wr_en = we; wr_data = wd; rd_en = re;
      #1;
      chk("ram_we", ram_we, int'(wr_ok));
      chk("ram_d", ram_d, wd);
      chk("ram_a", ram_a, wp);
      chk("ram_dpra", ram_dpra, rp);
      chk("full", full, int'(sz == 32));
      chk("empty", empty, int'(sz == 0));
      @(posedge clk); #1;
      if (rd_ok) begin last = q.pop_front(); rp = (rp + 1) % 32; end
      if (wr_ok) begin q.push_back(int'(wd)); wp = (wp + 1) % 32; end
      chk("count", count, q.size());
      chk("rd_valid", rd_valid, int'(rd_ok));
      chk("rd_data", rd_data, last);
      chk("overflow", overflow, int'(we && !wr_ok));
      chk("underflow", underflow, int'(re && !rd_ok));
      wr_en = 1'b0; rd_en = 1'b0;
   endtask

   initial begin
      for (int i = 0; i < 32; i++) mem[i] = 4'($urandom);
      wr_en = 1'b0; rd_en = 1'b0; wr_data = '0; rst = 1'b0;
      #2 do_reset();

      tbl[0]  = '{1'b1, 4'd0, 1'b0, 1, 1'b0, 4'd0, 1'b0, 1'b0};
      tbl[1]  = '{1'b1, 4'd1, 1'b0, 2, 1'b0, 4'd0, 1'b0, 1'b0};
      tbl[2]  = '{1'b1, 4'd2, 1'b0, 3, 1'b0, 4'd0, 1'b0, 1'b0};
      tbl[3]  = '{1'b1, 4'd3, 1'b0, 4, 1'b0, 4'd0, 1'b0, 1'b0};
      tbl[4]  = '{1'b1, 4'd4, 1'b0, 5, 1'b0, 4'd0, 1'b0, 1'b0};
      tbl[5]  = '{1'b0, 4'd0, 1'b1, 4, 1'b1, 4'd0, 1'b0, 1'b0};
      tbl[6]  = '{1'b0, 4'd0, 1'b1, 3, 1'b1, 4'd1, 1'b0, 1'b0};
      tbl[7]  = '{1'b0, 4'd0, 1'b1, 2, 1'b1, 4'd2, 1'b0, 1'b0};
      tbl[8]  = '{1'b0, 4'd0, 1'b1, 1, 1'b1, 4'd3, 1'b0, 1'b0};
      tbl[9]  = '{1'b0, 4'd0, 1'b1, 0, 1'b1, 4'd4, 1'b0, 1'b0};
      tbl[10] = '{1'b0, 4'd0, 1'b1, 0, 1'b0, 4'd4, 1'b0, 1'b1};
      tbl[11] = '{1'b1, 4'd9, 1'b1, 1, 1'b0, 4'd4, 1'b0, 1'b1};
      tbl[12] = '{1'b0, 4'd0, 1'b1, 0, 1'b1, 4'd9, 1'b0, 1'b0};
      tbl[13] = '{1'b0, 4'd0, 1'b0, 0, 1'b0, 4'd9, 1'b0, 1'b0};
      for (int i = 0; i < 14; i++) begin
         cycle(tbl[i].we, tbl[i].wd, tbl[i].re);
         chk("tbl_count", count, tbl[i].cnt);
         chk("tbl_rd_valid", rd_valid, tbl[i].v);
         chk("tbl_rd_data", rd_data, tbl[i].d);
         chk("tbl_overflow", overflow, tbl[i].ovf);
         chk("tbl_underflow", underflow, tbl[i].udf);
         if (i == 4) begin
            chk("push5_ram_a", ram_a, 5);
            chk("push5_empty", empty, 0);
         end
         if (i == 9) begin
            chk("pop5_empty", empty, 1);
            chk("pop5_ram_dpra", ram_dpra, 5);
         end
      end

      do_reset();
      for (int i = 0; i < 32; i++) cycle(1'b1, 4'(i % 16), 1'b0);
      chk("fill_full", full, 1);
      chk("fill_count", count, 32);
      cycle(1'b1, 4'd5, 1'b0);
      chk("ovf_pulse", overflow, 1);
      chk("ovf_count", count, 32);
      for (int i = 0; i < 40; i++) cycle(1'b1, 4'($urandom), 1'b1);
      chk("wrap_count", count, 32);
      chk("wrap_ram_a", ram_a, 8);
      chk("wrap_ram_dpra", ram_dpra, 8);

      for (int i = 0; i < 400; i++) begin
         if (i < 200) cycle($urandom_range(0, 3) != 0, 4'($urandom), $urandom_range(0, 3) == 0);
         else         cycle($urandom_range(0, 3) == 0, 4'($urandom), $urandom_range(0, 3) != 0);
      end

      do_reset();
      for (int i = 0; i < 8; i++) cycle(1'b1, 4'(i + 3), 1'b0);
      cycle(1'b0, 4'd0, 1'b1);
      chk("mid_count7", count, 7);
      do_reset();
      cycle(1'b1, 4'd10, 1'b0);
      cycle(1'b0, 4'd0, 1'b1);
      chk("post_rst_data", rd_data, 10);
      chk("post_rst_valid", rd_valid, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
